// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_stage_pkg                                                      |
// | Next-PC select encodings and the NOP word shared by the IF/ID stage. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package if_id_stage_pkg;

  localparam logic [1:0]  PC_SRC_SEQ = 2'b00;
  localparam logic [1:0]  PC_SRC_BR  = 2'b01;
  localparam logic [1:0]  PC_SRC_J   = 2'b10;
  localparam logic [1:0]  PC_SRC_JR  = 2'b11;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_register                                                          |
// | Program counter flop with reset value and write enable.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (en) begin
      r_pc <= d;
    end
  end

  assign q = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_stage                                                          |
// | Fetch stage and IF/ID register with stall/flush control and counters.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic             flush,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_instruction,
  output logic [31:0]      IF_ID_pc_plus4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;
  logic [31:0]      r_instruction;
  logic [31:0]      r_pc_plus4;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  assign w_pc_plus4 = pc + 32'd4;

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (pc_src)
      PC_SRC_SEQ: w_next_pc = w_pc_plus4;
      PC_SRC_BR:  w_next_pc = branch_target;
      PC_SRC_J:   w_next_pc = jump_target;
      PC_SRC_JR:  w_next_pc = jr_target;
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk (clk),
    .rst (rst),
    .en  (pc_write),
    .d   (w_next_pc),
    .q   (pc)
  );

  // A stall outranks a flush: branch operands are not resolved while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instruction <= 32'h0000_0000;
      r_pc_plus4    <= 32'h0000_0000;
      r_valid       <= 1'b0;
    end else if (!IF_ID_write) begin
      r_instruction <= r_instruction;
      r_pc_plus4    <= r_pc_plus4;
      r_valid       <= r_valid;
    end else if (flush) begin
      r_instruction <= NOP_INSTR;
      r_pc_plus4    <= 32'h0000_0000;
      r_valid       <= 1'b0;
    end else begin
      r_instruction <= instruction;
      r_pc_plus4    <= w_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!pc_write && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + C_CNT_ONE;
      end
      if (IF_ID_write && flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + C_CNT_ONE;
      end
    end
  end

  assign IF_ID_instruction = r_instruction;
  assign IF_ID_pc_plus4    = r_pc_plus4;
  assign IF_ID_valid       = r_valid;
  assign stall_count       = r_stall_count;
  assign flush_count       = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_id_stage                                                       |
// | Scoreboard bench for if_id_stage with 4-bit counters.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_if_id_stage;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      ins;
    logic [31:0]      p4;
    logic             v;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pc_write = 1'b1;
  logic             IF_ID_write = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       pc_src = 2'b00;
  logic [31:0]      branch_target = '0;
  logic [31:0]      jump_target = '0;
  logic [31:0]      jr_target = '0;
  logic [31:0]      instruction;
  logic [31:0]      pc;
  logic [31:0]      IF_ID_instruction;
  logic [31:0]      IF_ID_pc_plus4;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  int errors = 0;
  int checks = 0;

  obs_t sb[$];
  obs_t m = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  assign instruction = imem(pc);

  if_id_stage #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_write          (pc_write),
    .IF_ID_write       (IF_ID_write),
    .flush             (flush),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .jump_target       (jump_target),
    .jr_target         (jr_target),
    .instruction       (instruction),
    .pc                (pc),
    .IF_ID_instruction (IF_ID_instruction),
    .IF_ID_pc_plus4    (IF_ID_pc_plus4),
    .IF_ID_valid       (IF_ID_valid),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  function automatic obs_t observe();
    return '{pc, IF_ID_instruction, IF_ID_pc_plus4, IF_ID_valid, stall_count, flush_count};
  endfunction

  // Drive one cycle, advance the reference model, push its prediction, then sample after the edge.
  task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                       input logic [1:0] src, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] jrt);
    logic [31:0] nxt;
    @(negedge clk);
    rst = r; pc_write = pw; IF_ID_write = iw; flush = fl;
    pc_src = src; branch_target = bt; jump_target = jt; jr_target = jrt;
    if (r) begin
      m = '0;
      m.pc = RESET_PC;
    end else begin
      case (src)
        2'b00:   nxt = m.pc + 32'd4;
        2'b01:   nxt = bt;
        2'b10:   nxt = jt;
        default: nxt = jrt;
      endcase
      if (iw && fl) begin
        m.ins = 32'h0; m.p4 = 32'h0; m.v = 1'b0;
        if (m.fc != 4'hF) m.fc = m.fc + 4'd1;
      end else if (iw) begin
        m.ins = imem(m.pc); m.p4 = m.pc + 32'd4; m.v = 1'b1;
      end
      if (!pw && m.sc != 4'hF) m.sc = m.sc + 4'd1;
      if (pw) m.pc = nxt;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL reset_sb got=%h exp=%h", observe(), e);
      end
    end
    checks++;
    if ({pc, IF_ID_valid, stall_count, flush_count} !== {32'h0, 1'b0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_values pc=%h v=%b sc=%h fc=%h exp pc=0 v=0 sc=0 fc=0",
               pc, IF_ID_valid, stall_count, flush_count);
    end
  endtask

  task automatic test_sequential();
    obs_t e;
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL seq_sb got=%h exp=%h", observe(), e);
      end
      checks++;
      if (pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_pc got=%h exp=%h", pc, 32'(4 * i));
      end
    end
    checks++;
    if (IF_ID_instruction !== imem(32'h4) || IF_ID_pc_plus4 !== 32'h8 || IF_ID_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_ifid got=%h/%h/%b exp=%h/8/1", IF_ID_instruction, IF_ID_pc_plus4,
               IF_ID_valid, imem(32'h4));
    end
  endtask

  task automatic test_load_use_stall();
    obs_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL stall_sb got=%h exp=%h", observe(), e);
    end
    checks++;
    if (pc !== 32'h8 || IF_ID_instruction !== imem(32'h4) || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL stall_hold pc=%h ins=%h sc=%h exp pc=8 ins=%h sc=1", pc,
               IF_ID_instruction, stall_count, imem(32'h4));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'hC || IF_ID_instruction !== imem(32'h8) || observe() !== e) begin
      errors++;
      $display("FAIL stall_resume got=%h exp=%h", observe(), e);
    end
  endtask

  task automatic test_branch_flush();
    obs_t e;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h40, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'h40 || IF_ID_instruction !== 32'h0 || IF_ID_valid !== 1'b0 ||
        flush_count !== 4'd1 || observe() !== e) begin
      errors++;
      $display("FAIL branch_flush got=%h exp=%h", observe(), e);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL branch_after got=%h exp=%h", observe(), e);
    end
  endtask

  task automatic test_stall_and_flush();
    obs_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h80, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'h44 || IF_ID_instruction !== imem(32'h40) || IF_ID_valid !== 1'b1 ||
        flush_count !== 4'd1 || stall_count !== 4'd2 || observe() !== e) begin
      errors++;
      $display("FAIL stall_flush got=%h exp=%h", observe(), e);
    end
  endtask

  task automatic test_jumps_wrap();
    obs_t e;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h100, 32'h0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'h100 || observe() !== e) begin
      errors++;
      $display("FAIL jump got=%h exp=%h", observe(), e);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'hFFFF_FFFC || observe() !== e) begin
      errors++;
      $display("FAIL jr got=%h exp=%h", observe(), e);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (pc !== 32'h0 || IF_ID_pc_plus4 !== 32'h0 || IF_ID_valid !== 1'b1 ||
        IF_ID_instruction !== imem(32'hFFFF_FFFC) || observe() !== e) begin
      errors++;
      $display("FAIL wrap got=%h exp=%h", observe(), e);
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL sat_sb cycle=%0d got=%h exp=%h", i, observe(), e);
      end
    end
    checks++;
    if (stall_count !== 4'hF || flush_count !== 4'hF) begin
      errors++;
      $display("FAIL saturate sc=%h fc=%h exp sc=f fc=f", stall_count, flush_count);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h80, 32'h0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (observe() !== obs_t'({RESET_PC, 32'h0, 32'h0, 1'b0, 4'h0, 4'h0}) || observe() !== e) begin
      errors++;
      $display("FAIL reset_mid_stall got=%h exp=%h", observe(), e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic s;
    for (int i = 0; i < 60; i++) begin
      s = ($urandom_range(0, 3) == 0);
      drive(1'b0, ~s, ~s, ($urandom_range(0, 4) == 0), 2'($urandom),
            {$urandom_range(0, 255), 2'b00}, {$urandom_range(0, 255), 2'b00},
            {$urandom_range(0, 255), 2'b00});
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL b2b cycle=%0d got=%h exp=%h", i, observe(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load_use_stall();
    test_branch_flush();
    test_stall_and_flush();
    test_jumps_wrap();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
